// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared types for the I2C register slave and its bus filter.
//   i2c_slv_state_t : FSM state encoding (exported on debug_state)
//   i2c_bus_ev_t    : START/STOP condition strobes from the bus filter
//   I2C_ACK/NACK    : value of SDA during the acknowledge bit
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK      = 4'd8
    } i2c_slv_state_t;

    typedef struct packed {
        logic start;
        logic stop;
    } i2c_bus_ev_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_reg_slave_if.sv
// ---------------------------------------------------------------------------
// i2c_reg_slave_if
// Local host port of the register slave.
//   host_idx   : register index the host wants to read
//   host_rdata : regs[host_idx], registered (1 clk latency)
//   wr_pulse   : one-cycle strobe per byte committed by an I2C write
//   wr_idx     : register written, valid with wr_pulse
//   wr_data    : byte written, valid with wr_pulse
// wr_pulse is a plain strobe: there is no ready/back-pressure, the host
// must take wr_idx/wr_data in the cycle wr_pulse is high.
// ---------------------------------------------------------------------------
interface i2c_reg_slave_if #(
    parameter int PW = 3
);
    logic [PW-1:0] host_idx;
    logic [7:0]    host_rdata;
    logic          wr_pulse;
    logic [PW-1:0] wr_idx;
    logic [7:0]    wr_data;

    modport slave  (input  host_idx, output host_rdata, wr_pulse, wr_idx, wr_data);
    modport master (output host_idx, input  host_rdata, wr_pulse, wr_idx, wr_data);
endinterface

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Two-flop synchronizers on SCL/SDA followed by one edge-detect register.
//   clk, rst  : system clock, synchronous active-high reset
//   scl, sda  : raw bus pins
//   sda_s     : synchronized SDA level
//   scl_rise  : SCL rising edge strobe
//   scl_fall  : SCL falling edge strobe
//   ev        : START (SDA falls, SCL high) / STOP (SDA rises, SCL high)
// All strobes are single-cycle.
// ---------------------------------------------------------------------------
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda,
    output logic        sda_s,
    output logic        scl_rise,
    output logic        scl_fall,
    output i2c_bus_ev_t ev
);
    logic scl_m, scl_q, scl_d;
    logic sda_m, sda_q, sda_d;

    // The idle bus is high; resetting to 1 avoids fake edges after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_m <= 1'b1; scl_q <= 1'b1; scl_d <= 1'b1;
            sda_m <= 1'b1; sda_q <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_m <= scl;  scl_q <= scl_m; scl_d <= scl_q;
            sda_m <= sda;  sda_q <= sda_m; sda_d <= sda_q;
        end
    end

    assign sda_s    = sda_q;
    assign scl_rise =  scl_q & ~scl_d;
    assign scl_fall = ~scl_q &  scl_d;
    // SCL must be high on both samples so an SDA change next to an SCL
    // edge is not mistaken for a bus condition.
    assign ev.start = scl_q & scl_d & ~sda_q &  sda_d;
    assign ev.stop  = scl_q & scl_d &  sda_q & ~sda_d;
endmodule

// File: rtl/i2c_reg_slave.sv
// ---------------------------------------------------------------------------
// i2c_reg_slave
// I2C responder with a NUM_REGS x 8 register file, auto-incrementing
// pointer and read-back. Write: S addr+W ptr d0 d1 .. P. Read: S addr+R
// then bytes from the current pointer until the master NACKs.
//   clk, rst          : system clock, synchronous active-high reset
//   scl               : I2C clock (input only)
//   sda               : I2C data, open-drain (drives 0 or z)
//   host              : local host port (read index/data, write notify)
//   debug_addr_match  : high from address match until START/STOP
//   debug_state       : current FSM state
// ---------------------------------------------------------------------------
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h58,
    parameter int         NUM_REGS   = 8,
    localparam int        PW         = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    inout  wire                   sda,
    i2c_reg_slave_if.slave        host,
    output logic                  debug_addr_match,
    output logic [3:0]            debug_state
);
    logic        sda_s, scl_rise, scl_fall;
    i2c_bus_ev_t ev;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .ev       (ev)
    );

    i2c_slv_state_t state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           sda_oe_q, sda_oe_d;
    logic           rw_q, rw_d;
    logic           match_q, match_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic           do_commit;
    logic [7:0]     regs [NUM_REGS];
    logic [7:0]     rx_byte;
    logic [7:0]     rd_byte;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign rd_byte = regs[ptr_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        sda_oe_d  = sda_oe_q;
        rw_d      = rw_q;
        match_d   = match_q;
        ptr_d     = ptr_q;
        do_commit = 1'b0;

        if (ev.start) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            match_d  = 1'b0;
        end else if (ev.stop) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            match_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    state_d = ST_ADDR_ACK;
                                    rw_d    = rx_byte[0];
                                    match_d = 1'b1;
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d   = rx_byte[PW-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                // Commit happens on entry to WDATA_ACK,
                                // before the ACK bit is driven.
                                do_commit = 1'b1;
                                ptr_d     = ptr_q + PW'(1);
                                state_d   = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    // First SCL fall starts the ACK, second one ends it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (state_q == ST_ADDR_ACK && rw_q) begin
                            // The first read bit launches on the same fall
                            // that ends the address ACK.
                            sda_oe_d = ~rd_byte[7];
                            shift_d  = {rd_byte[6:0], 1'b0};
                            cnt_d    = 4'd1;
                            state_d  = ST_RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            // Byte fully sent: release for the master's ACK.
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            ptr_d    = ptr_q + PW'(1);
                            state_d  = ST_RACK;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            shift_d = rd_byte;
                            cnt_d   = '0;
                            state_d = ST_RDATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            shift_q         <= '0;
            sda_oe_q        <= 1'b0;
            rw_q            <= 1'b0;
            match_q         <= 1'b0;
            ptr_q           <= '0;
            host.host_rdata <= '0;
            host.wr_pulse   <= 1'b0;
            host.wr_idx     <= '0;
            host.wr_data    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            shift_q         <= shift_d;
            sda_oe_q        <= sda_oe_d;
            rw_q            <= rw_d;
            match_q         <= match_d;
            ptr_q           <= ptr_d;
            host.host_rdata <= regs[host.host_idx];
            host.wr_pulse   <= do_commit;
            if (do_commit) begin
                regs[ptr_q]  <= rx_byte;
                host.wr_idx  <= ptr_q;
                host.wr_data <= rx_byte;
            end
        end
    end

    // Reset gates the driver directly so SDA is let go in the same cycle
    // reset is applied, not one clock later.
    assign sda = (sda_oe_q && !rst) ? 1'b0 : 1'bz;

    assign debug_addr_match = match_q;
    assign debug_state      = state_q;
endmodule

// File: tb/tb_i2c_reg_slave.sv
module tb_i2c_reg_slave;
    import i2c_pkg::*;

    // ---------------- clock / reset / bus ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;
    logic       dbg_match;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_reg_slave_if #(.PW(3)) host ();

    i2c_reg_slave #(.SLAVE_ADDR(7'h58), .NUM_REGS(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .scl              (scl),
        .sda              (sda),
        .host             (host),
        .debug_addr_match (dbg_match),
        .debug_state      (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  model_regs [8];
    int          model_ptr = 0;
    logic [10:0] exp_q [$];
    logic [10:0] mon_e;
    logic [7:0]  tx [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every write notification must match the next expected (idx,data).
    always @(negedge clk) begin
        if (!rst && host.wr_pulse) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_event", {21'd0, host.wr_idx, host.wr_data}, {21'd0, mon_e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; tick(10);
        scl = 1'b1;       tick(10);
        m_sda_low = 1'b1; tick(10);
        scl = 1'b0;       tick(10);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; tick(10);
        scl = 1'b1;       tick(10);
        m_sda_low = 1'b0; tick(20);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; tick(10);
        scl = 1'b1;     tick(20);
        scl = 1'b0;     tick(10);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; tick(10);
        scl = 1'b1;       tick(10);
        b = sda;          tick(10);
        scl = 1'b0;       tick(10);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    // S 0xB0 ptr tx[...] [P]
    task automatic i2c_write(input logic [7:0] pbyte, input bit stop_after);
        logic ack;
        i2c_start();
        write_byte(8'hB0, ack);
        check("addr_ack", ack, 0);
        check("addr_match", dbg_match, 1);
        write_byte(pbyte, ack);
        check("ptr_ack", ack, 0);
        model_ptr = pbyte % 8;
        foreach (tx[i]) begin
            model_regs[model_ptr] = tx[i];
            exp_q.push_back({model_ptr[2:0], tx[i]});
            model_ptr = (model_ptr + 1) % 8;
            write_byte(tx[i], ack);
            check("data_ack", ack, 0);
        end
        if (stop_after) i2c_stop();
    endtask

    // S/Sr 0xB1, n bytes (ACK all but last, NACK last), P
    task automatic i2c_read(input int n);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hB1, ack);
        check("raddr_ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            read_byte(d, (i == n - 1) ? 1'b1 : 1'b0);
            check("rdata", d, model_regs[model_ptr]);
            model_ptr = (model_ptr + 1) % 8;
        end
        check("nack_release", sda, 1);
        check("nack_idle", dbg_state, ST_IDLE);
        i2c_stop();
    endtask

    task automatic host_readback();
        for (int i = 0; i < 8; i++) begin
            host.host_idx = i[2:0];
            tick(2);
            check("host_rdata", host.host_rdata, model_regs[i]);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic ack;
        int   n;

        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
        host.host_idx = '0;
        tick(5);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_match", dbg_match, 0);
        check("rst_wr_pulse", host.wr_pulse, 0);
        check("rst_sda", sda, 1);
        rst = 1'b0;
        tick(5);
        check("rst_rdata", host.host_rdata, 0);

        // Basic write: ptr 2, data AA 55
        tx = '{8'hAA, 8'h55};
        i2c_write(8'h02, 1);
        host.host_idx = 3'd3;
        tick(2);
        check("host_idx3", host.host_rdata, 8'h55);

        // Pointer wrap 7 -> 0
        tx = '{8'h11, 8'h22};
        i2c_write(8'h07, 1);
        host_readback();

        // Pointer write, repeated START, read 3 bytes; pointer ends at 4
        tx = {};
        i2c_write(8'h01, 0);
        i2c_read(3);
        i2c_read(1);

        // Foreign address: no ACK, no match, no register change
        i2c_start();
        write_byte(8'hA0, ack);
        check("bad_addr_nack", ack, 1);
        check("bad_addr_match", dbg_match, 0);
        i2c_stop();
        host_readback();

        // STOP in the middle of a data byte
        i2c_start();
        write_byte(8'hB0, ack);
        check("abort_addr_ack", ack, 0);
        write_byte(8'h05, ack);
        check("abort_ptr_ack", ack, 0);
        model_ptr = 5;
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        i2c_stop();
        tick(5);
        check("abort_idle", dbg_state, ST_IDLE);
        check("abort_match", dbg_match, 0);
        tx = '{8'h3C};
        i2c_write(8'h06, 1);
        host_readback();

        // Random transfers: pointer byte upper bits must be ignored
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(0, 4);
            tx = {};
            for (int j = 0; j < n; j++) tx.push_back(8'($urandom_range(0, 255)));
            i2c_write(8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
            i2c_read($urandom_range(1, 5));
        end
        host_readback();

        // Reset while the slave is driving an ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : ((8'hB0 >> i) & 1'b1) == 1'b1);
        m_sda_low = 1'b0;
        tick(2);
        check("ack_driven", sda, 0);
        rst = 1'b1;
        #1;
        check("rst_sda_release", sda, 1);
        tick(3);
        scl = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(5);
        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        check("rst2_state", dbg_state, ST_IDLE);
        host_readback();
        i2c_read(2);

        tick(10);
        check("wr_missing", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
